// File: rtl/led_matrix_scan_driver.sv
// Column-scan LED matrix driver: holds a double-buffered frame and drives it
// one column at a time, with an all-off blanking gap between columns.
module led_matrix_scan_driver #(
   parameter int ROWS           = 7,
   parameter int COLS           = 5,
   parameter int TICK_DIV       = 1000,
   parameter int BLANK_CYCLES   = 4,
   parameter int COL_ACTIVE_LOW = 1
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      enable,
   input  logic [ROWS*COLS-1:0]                      frame_data,
   input  logic                                      frame_valid,
   output logic                                      frame_ready,
   output logic [ROWS-1:0]                           row_out,
   output logic [COLS-1:0]                           col_out,
   output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col_index,
   output logic                                      frame_done
);

   localparam int IW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int MAXC = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int FW   = ROWS * COLS;

   localparam logic [CW-1:0]   DRIVE_LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0]   BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0]   COL_LAST   = IW'(COLS - 1);
   localparam logic [COLS-1:0] COL_OFF    = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   // With no blanking configured the scan goes straight from one column's drive to the next.
   localparam state_t AFTER_DRIVE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [IW-1:0]   col_nxt;
   logic [FW-1:0]   active;
   logic [FW-1:0]   pending;
   logic [FW-1:0]   active_nxt;
   logic            accept;
   logic            scan_end;
   logic            boundary;

   // frame_ready doubles as the "pending buffer empty" flag.
   always_comb begin
      accept   = frame_valid && frame_ready;
      scan_end = enable && (state == DRIVE) && (cnt == DRIVE_LAST) && (col_index == COL_LAST);
      boundary = scan_end || (enable && (state == IDLE));

      active_nxt = active;
      if (boundary) begin
         if (!frame_ready) begin
            active_nxt = pending;
         end else if (accept) begin
            active_nxt = frame_data;
         end
      end

      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      col_nxt   = col_index;
      if (!enable) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         col_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = AFTER_DRIVE;
               cnt_nxt   = '0;
               col_nxt   = '0;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = '0;
               end
            end
            DRIVE: begin
               if (cnt == DRIVE_LAST) begin
                  state_nxt = AFTER_DRIVE;
                  cnt_nxt   = '0;
                  col_nxt   = (col_index == COL_LAST) ? '0 : col_index + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               col_nxt   = '0;
            end
         endcase
      end
   end

   // Outputs are computed from the next state and the next active frame so they
   // line up with the state they belong to, including a swap at the boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         col_index   <= '0;
         row_out     <= '0;
         col_out     <= COL_OFF;
         frame_done  <= 1'b0;
         frame_ready <= 1'b1;
         active      <= '0;
         pending     <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         col_index  <= col_nxt;
         active     <= active_nxt;
         frame_done <= scan_end;

         if (boundary && !frame_ready) begin
            frame_ready <= 1'b1;
         end else if (accept && !boundary) begin
            pending     <= frame_data;
            frame_ready <= 1'b0;
         end

         if (state_nxt == DRIVE) begin
            row_out <= active_nxt[col_nxt*ROWS +: ROWS];
            col_out <= COL_OFF ^ (COLS'(1) << col_nxt);
         end else begin
            row_out <= '0;
            col_out <= COL_OFF;
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Bench for led_matrix_scan_driver: a directed vector table, hand-written
// handshake/enable/reset sequences and a random phase against a position-based model.
module tb_led_matrix_scan_driver;

   localparam int ROWS  = 7;
   localparam int COLS  = 5;
   localparam int TICK  = 4;
   localparam int BLANK = 2;
   localparam int FW    = ROWS * COLS;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            enable = 1'b0;
   logic            frame_valid = 1'b0;
   logic [FW-1:0]   frame_data = '0;

   logic            frame_ready;
   logic [ROWS-1:0] row_out;
   logic [COLS-1:0] col_out;
   logic [2:0]      col_index;
   logic            frame_done;

   logic            frame_ready_z;
   logic [ROWS-1:0] row_out_z;
   logic [COLS-1:0] col_out_z;
   logic [2:0]      col_index_z;
   logic            frame_done_z;

   int n_checks = 0;
   int n_fail   = 0;

   led_matrix_scan_driver #(
      .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK), .BLANK_CYCLES(BLANK), .COL_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_data(frame_data),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .row_out(row_out),
      .col_out(col_out), .col_index(col_index), .frame_done(frame_done)
   );

   // Second instance without blanking, sharing the same stimulus.
   led_matrix_scan_driver #(
      .ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK), .BLANK_CYCLES(0), .COL_ACTIVE_LOW(1)
   ) dut_nb (
      .clk(clk), .rst_n(rst_n), .enable(enable), .frame_data(frame_data),
      .frame_valid(frame_valid), .frame_ready(frame_ready_z), .row_out(row_out_z),
      .col_out(col_out_z), .col_index(col_index_z), .frame_done(frame_done_z)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            run;
      int            pos;
      logic [FW-1:0] active;
      logic [FW-1:0] pending;
      bit            ready;
      logic [ROWS-1:0] row;
      logic [COLS-1:0] col;
      int            idx;
      bit            done;
   } model_t;

   typedef struct {
      bit              en;
      bit              valid;
      logic [COLS-1:0] col;
      logic [ROWS-1:0] row;
      logic [2:0]      idx;
      bit              done;
      bit              ready;
   } vec_t;

   model_t m2;
   model_t m0;
   vec_t   vecs[14];
   logic [FW-1:0] frame_a, frame_b, frame_c, frame_d, frame_e;

   function automatic model_t model_reset();
      model_t r;
      r.run = 1'b0; r.pos = 0; r.active = '0; r.pending = '0; r.ready = 1'b1;
      r.row = '0; r.col = '1; r.idx = 0; r.done = 1'b0;
      return r;
   endfunction

   // The scan is modelled as a position within the frame period; column and
   // blank/drive phase follow from division by the per-column slot length.
   function automatic model_t model_step(input model_t m, input int blank, input bit en,
                                         input bit valid, input logic [FW-1:0] data);
      model_t n;
      int     per;
      bit     acc;
      bit     bnd;
      n      = m;
      per    = blank + TICK;
      acc    = valid && m.ready;
      bnd    = 1'b0;
      n.done = 1'b0;
      if (!en) begin
         n.run = 1'b0;
         n.pos = 0;
      end else if (!m.run) begin
         n.run = 1'b1;
         n.pos = 0;
         bnd   = 1'b1;
      end else begin
         bnd    = (m.pos == COLS * per - 1);
         n.done = bnd;
         n.pos  = (m.pos + 1) % (COLS * per);
      end
      if (bnd && !m.ready) begin
         n.active = m.pending;
         n.ready  = 1'b1;
      end else if (bnd && acc) begin
         n.active = data;
      end else if (acc) begin
         n.pending = data;
         n.ready   = 1'b0;
      end
      n.row = '0;
      n.col = '1;
      n.idx = 0;
      if (n.run) begin
         n.idx = n.pos / per;
         if ((n.pos % per) >= blank) begin
            n.row = n.active[n.idx*ROWS +: ROWS];
            n.col = ~(COLS'(1) << n.idx);
         end
      end
      return n;
   endfunction

   function automatic vec_t mkVec(input bit en, input bit valid, input logic [COLS-1:0] col,
                                  input logic [ROWS-1:0] row, input logic [2:0] idx,
                                  input bit done, input bit ready);
      vec_t v;
      v.en = en; v.valid = valid; v.col = col; v.row = row; v.idx = idx;
      v.done = done; v.ready = ready;
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOneHot(input string name, input logic [COLS-1:0] c);
      n_checks++;
      if ($countones(~c) > 1) begin
         n_fail++;
         $display("[TB] FAIL %s: got col_out %b, expected at most one active column", name, c);
      end
   endtask

   task automatic checkOutput();
      checkValue("row_out",        row_out,       m2.row);
      checkValue("col_out",        col_out,       m2.col);
      checkValue("col_index",      col_index,     m2.idx);
      checkValue("frame_done",     frame_done,    m2.done);
      checkValue("frame_ready",    frame_ready,   m2.ready);
      checkValue("nb_row_out",     row_out_z,     m0.row);
      checkValue("nb_col_out",     col_out_z,     m0.col);
      checkValue("nb_col_index",   col_index_z,   m0.idx);
      checkValue("nb_frame_done",  frame_done_z,  m0.done);
      checkValue("nb_frame_ready", frame_ready_z, m0.ready);
      checkOneHot("onehot",    col_out);
      checkOneHot("nb_onehot", col_out_z);
   endtask

   task automatic applyStimulus(input bit en, input bit valid, input logic [FW-1:0] data);
      enable      = en;
      frame_valid = valid;
      frame_data  = data;
   endtask

   task automatic tick();
      m2 = model_step(m2, BLANK, enable, frame_valid, frame_data);
      m0 = model_step(m0, 0, enable, frame_valid, frame_data);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_done && n < 64);
      checkValue(name, frame_done, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int accepts;
      int done_seen;

      for (int c = 0; c < COLS; c++) frame_a[c*ROWS +: ROWS] = ROWS'(1 << c);
      frame_b = FW'({$urandom, $urandom}); frame_b[ROWS-1:0] = 7'h55;
      frame_c = FW'({$urandom, $urandom}); frame_c[ROWS-1:0] = 7'h2A;
      frame_d = FW'({$urandom, $urandom}); frame_d[ROWS-1:0] = 7'h33;
      frame_e = FW'({$urandom, $urandom}); frame_e[ROWS-1:0] = 7'h4C;

      vecs[0]  = mkVec(0, 1, 5'h1F, 7'h00, 3'd0, 0, 0);
      vecs[1]  = mkVec(1, 0, 5'h1F, 7'h00, 3'd0, 0, 1);
      vecs[2]  = mkVec(1, 0, 5'h1F, 7'h00, 3'd0, 0, 1);
      vecs[3]  = mkVec(1, 0, 5'h1E, 7'h01, 3'd0, 0, 1);
      vecs[4]  = mkVec(1, 0, 5'h1E, 7'h01, 3'd0, 0, 1);
      vecs[5]  = mkVec(1, 0, 5'h1E, 7'h01, 3'd0, 0, 1);
      vecs[6]  = mkVec(1, 0, 5'h1E, 7'h01, 3'd0, 0, 1);
      vecs[7]  = mkVec(1, 0, 5'h1F, 7'h00, 3'd1, 0, 1);
      vecs[8]  = mkVec(1, 0, 5'h1F, 7'h00, 3'd1, 0, 1);
      vecs[9]  = mkVec(1, 0, 5'h1D, 7'h02, 3'd1, 0, 1);
      vecs[10] = mkVec(1, 0, 5'h1D, 7'h02, 3'd1, 0, 1);
      vecs[11] = mkVec(1, 0, 5'h1D, 7'h02, 3'd1, 0, 1);
      vecs[12] = mkVec(1, 0, 5'h1D, 7'h02, 3'd1, 0, 1);
      vecs[13] = mkVec(1, 0, 5'h1F, 7'h00, 3'd2, 0, 1);

      m2 = model_reset();
      m0 = model_reset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      rst_n = 1'b1;

      // Load frame A while idle, then start the scan.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].en, vecs[i].valid, frame_a);
         tick();
         checkValue("vec_col_out",     col_out,     vecs[i].col);
         checkValue("vec_row_out",     row_out,     vecs[i].row);
         checkValue("vec_col_index",   col_index,   vecs[i].idx);
         checkValue("vec_frame_done",  frame_done,  vecs[i].done);
         checkValue("vec_frame_ready", frame_ready, vecs[i].ready);
      end

      waitDone("first_frame_done");
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_done && n < 64);
      checkValue("frame_period", n, 30);

      // Frame B offered mid-scan waits in pending until the boundary.
      repeat (5) tick();
      applyStimulus(1, 1, frame_b);
      tick();
      checkValue("ready_after_accept", frame_ready, 1'b0);
      applyStimulus(1, 0, frame_b);
      waitDone("done_with_pending");
      checkValue("ready_after_swap", frame_ready, 1'b1);
      repeat (2) tick();
      checkValue("frame_b_col0", row_out, frame_b[ROWS-1:0]);

      // Frame D fills pending; frame C is then held valid and must be taken exactly once.
      applyStimulus(1, 1, frame_d);
      tick();
      accepts = 0;
      applyStimulus(1, 1, frame_c);
      repeat (35) begin
         if (frame_valid && frame_ready) accepts++;
         tick();
      end
      checkValue("held_frame_accepts", accepts, 1);
      applyStimulus(1, 0, frame_c);

      // Bypass: offer on the last drive cycle with pending empty.
      waitDone("done_before_bypass");
      repeat (29) tick();
      applyStimulus(1, 1, frame_e);
      tick();
      checkValue("bypass_done",  frame_done,  1'b1);
      checkValue("bypass_ready", frame_ready, 1'b1);
      applyStimulus(1, 0, frame_e);
      repeat (2) tick();
      checkValue("bypass_col0", row_out, frame_e[ROWS-1:0]);

      // Drop enable while column 3 is driven.
      waitDone("done_before_disable");
      repeat (20) tick();
      checkValue("col3_index", col_index, 3'd3);
      checkValue("col3_col_out", col_out, 5'b10111);
      applyStimulus(0, 0, frame_e);
      tick();
      checkValue("disable_col_out", col_out, 5'h1F);
      checkValue("disable_row_out", row_out, 7'h00);
      done_seen = 0;
      repeat (15) begin
         tick();
         if (frame_done) done_seen++;
      end
      checkValue("no_done_partial", done_seen, 0);
      applyStimulus(1, 0, frame_e);
      repeat (3) tick();
      checkValue("restart_col_out", col_out, 5'b11110);
      checkValue("restart_index",   col_index, 3'd0);
      checkValue("restart_row_out", row_out, frame_e[ROWS-1:0]);

      // Asynchronous reset mid-drive, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      m2 = model_reset();
      m0 = model_reset();
      checkValue("async_col_out",   col_out,   5'h1F);
      checkValue("async_row_out",   row_out,   7'h00);
      checkValue("async_col_index", col_index, 3'd0);
      checkValue("async_nb_col_out", col_out_z, 5'h1F);
      @(posedge clk);
      #1;
      checkOutput();
      rst_n = 1'b1;

      // Random phase.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                       FW'({$urandom, $urandom}));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/led_matrix_scan_driver.md
Name: led_matrix_scan_driver

Overview:
- Parametrised, clocked column-scan driver for the LED matrix. It replaces the fixed combinational row mux.
- Holds a double-buffered frame and time-multiplexes it one column at a time. Each column is followed by a blanking interval to suppress ghosting.
- Sits between the display controller (frame handshake) and the matrix row/column pins.

Parameters:
- ROWS, 7, rows per column (row_out width).
- COLS, 5, columns scanned per frame.
- TICK_DIV, 1000, clk cycles each column is driven (>=1).
- BLANK_CYCLES, 4, clk cycles of all-off between columns (>=0; 0 means no blanking).
- COL_ACTIVE_LOW, 1, 1 means the selected column is driven 0 and the others 1; 0 means the reverse.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, reset. Asynchronous, active-low.
- enable, in, 1, scan enable.
- frame_data, in, ROWS*COLS, pixel bits. Bit c*ROWS+r is the pixel at row r, column c; 1 means lit.
- frame_valid, in, 1, producer has a frame on frame_data.
- frame_ready, out, 1, pending buffer is empty and can accept a frame.
- row_out, out, ROWS, active-high row drive.
- col_out, out, COLS, one-hot column select, polarity set by COL_ACTIVE_LOW.
- col_index, out, max(1,$clog2(COLS)), column currently in BLANK or DRIVE.
- frame_done, out, 1, one-cycle pulse at the end of each full scan.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, row_out = 0, col_out = all inactive, col_index = 0.
  - frame_done = 0, frame_ready = 1, active buffer = 0, pending buffer empty.
- All outputs are registered.
- Handshake:
  - A frame is accepted when frame_valid && frame_ready.
  - An accepted frame is stored in the pending buffer. frame_ready drops the following cycle and stays low while pending is full.
  - Data on frame_data is sampled only on the accept cycle.
- Frame boundary is defined as either the IDLE->BLANK transition or the last DRIVE cycle of column COLS-1.
- Action at a frame boundary:
  - If pending is full: pending is copied to the active buffer, pending is emptied, and frame_ready returns to 1 next cycle.
  - If pending is empty and an accept occurs in that same cycle: the accepted frame goes directly into the active buffer and pending stays empty (bypass).
  - Otherwise the active buffer is unchanged; the old frame repeats.
- State IDLE:
  - Outputs are blanked.
  - enable=1 moves to BLANK next cycle with col_index = 0. If BLANK_CYCLES = 0 it moves to DRIVE instead.
- State BLANK:
  - row_out = 0 and col_out is inactive.
  - Lasts exactly BLANK_CYCLES cycles, then moves to DRIVE.
- State DRIVE:
  - col_out has bit col_index active.
  - row_out = active[col_index*ROWS +: ROWS].
  - Lasts exactly TICK_DIV cycles.
  - On the last cycle, col_index increments, wrapping from COLS-1 to 0, and the state moves to BLANK (or DRIVE if BLANK_CYCLES = 0).
- Frame period is COLS*(BLANK_CYCLES+TICK_DIV) cycles.
- frame_done is high for exactly the one cycle after the last DRIVE cycle of column COLS-1.
- enable=0 in any state:
  - Next cycle the state is IDLE, counters are cleared, col_index = 0, and outputs are blanked.
  - No frame_done is issued for the partial frame.
  - The pending and active buffers are retained, and the handshake keeps operating while in IDLE.
- Never more than one column is active at any cycle, including at transitions.
- An asynchronous reset mid-scan forces the reset values immediately. The scan restarts from IDLE after rst_n deasserts.

Test Plan (ROWS=7, COLS=5, TICK_DIV=4, BLANK_CYCLES=2, COL_ACTIVE_LOW=1):
- Reset, then load a frame with column c = 7'h01<<c and set enable=1 -> DRIVE of col 0 starts 3 cycles after enable is sampled. col_out=5'b11110 and row_out=7'h01 for 4 cycles, then 2 blank cycles (col_out=5'b11111, row_out=0). frame_done pulses every 30 cycles.
- Offer frame B mid-scan -> accepted, frame_ready=0 until the frame boundary. Frame A is completed unchanged and column 0 of the next scan shows B.
- Hold frame_valid with a third frame while pending is full -> no accept until frame_ready rises. The frame is then accepted exactly once.
- Assert frame_valid with pending empty on the boundary cycle -> bypass, and the new frame is shown on the very next column 0.
- Drop enable during DRIVE of col 3 -> IDLE next cycle, outputs blanked, no frame_done. Re-enable -> the scan restarts at col 0.
- Pulse rst_n low mid-DRIVE -> outputs go to reset values without waiting for clk. With BLANK_CYCLES=0, the one-hot column check still passes every cycle.
